// File: rtl/memory_array_pkg.sv
// Shared types and constants for the memory_array macro.
package memory_array_pkg;

  // INIT sweeps zeros into every word; IDLE serves accesses.
  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  // Encoding of the rw mode bit, inherited from the single-bit cell.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/memory_word.sv
// One storage row of the array: a WIDTH-bit register with write enable.
// Rows carry no reset; the clear sweep is what gives them a known value.
module memory_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] word_q;

  // Hold the current word unless this row is being written.
  always_comb begin
    word_d = word_q;
    if (we) begin
      word_d = d;
    end
  end

  // Storage register.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign q = word_q;

endmodule

// File: rtl/memory_array.sv
// Word-addressed storage macro with a registered read path and a
// hardware clear sweep after reset or on a clr pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | clear sweep: zero word cnt each cycle, busy=1, no accesses
// IDLE  | serve reads/writes; clr restarts the sweep from word 0
module memory_array
  import memory_array_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             rw,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] in,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic [DEPTH-1:0] dec;
  logic [DEPTH-1:0] we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] word_q [DEPTH];
  logic             addr_hit;
  logic             acc_write;
  logic             acc_read;
  logic             sweep_last;

  // One-hot address decode; an address past the last word hits nothing.
  always_comb begin
    dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dec[i] = (addr == AW'(i));
    end
  end

  assign addr_hit = |dec;

  // AND-OR read mux; yields zero when the address is out of range.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdata = rdata | (word_q[i] & {WIDTH{dec[i]}});
    end
  end

  // clr takes priority over any access requested in the same cycle.
  assign acc_write  = (state_q == IDLE) && sel && !clr && (rw == RW_WRITE);
  assign acc_read   = (state_q == IDLE) && sel && !clr && (rw == RW_READ);
  assign sweep_last = (cnt_q == AW'(DEPTH - 1));

  // State, sweep counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state: sweep to the last word, then idle until clr.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (sweep_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: row write enables, write data and the next read register value.
  always_comb begin
    we          = '0;
    wdata       = in;
    out_d       = '0;
    out_valid_d = 1'b0;
    if (state_q == INIT) begin
      wdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
        we[i] = (cnt_q == AW'(i));
      end
    end else if (acc_write) begin
      we = dec;
    end
    if (acc_read) begin
      out_valid_d = 1'b1;
      out_d       = addr_hit ? rdata : '0;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_row
    memory_word #(.WIDTH(WIDTH)) u_word (
      .clk (clk),
      .we  (we[g]),
      .d   (wdata),
      .q   (word_q[g])
    );
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == INIT);

endmodule

// File: tb/tb_memory_array.sv
// Bench for memory_array: a DEPTH=16 and a DEPTH=10 instance driven with
// the same stimulus and compared against a per-instance behavioural model.
module tb_memory_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       rw = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] din = '0;
  logic       clr = 1'b0;

  logic [7:0] dout [2];
  logic       dv   [2];
  logic       db   [2];

  // model state per instance: 0 -> DEPTH 16, 1 -> DEPTH 10
  int         dep  [2] = '{16, 10};
  logic [7:0] m    [2][16];
  int         left [2];
  logic [7:0] eo   [2];
  logic       ev   [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  memory_array #(.WIDTH(8), .DEPTH(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rw(rw), .addr(addr), .in(din),
    .clr(clr), .out(dout[0]), .out_valid(dv[0]), .busy(db[0])
  );

  memory_array #(.WIDTH(8), .DEPTH(10)) u_d10 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rw(rw), .addr(addr), .in(din),
    .clr(clr), .out(dout[1]), .out_valid(dv[1]), .busy(db[1])
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all(input string step);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s d%0d busy", step, dep[k]), {7'd0, db[k]}, {7'd0, left[k] > 0});
      chk($sformatf("%s d%0d out_valid", step, dep[k]), {7'd0, dv[k]}, {7'd0, ev[k]});
      chk($sformatf("%s d%0d out", step, dep[k]), dout[k], eo[k]);
    end
  endtask

  // Reset puts every instance into a fresh sweep; the sweep ends with all words zero.
  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      left[k] = dep[k];
      eo[k] = '0;
      ev[k] = 1'b0;
      for (int j = 0; j < 16; j++) m[k][j] = '0;
    end
  endfunction

  function automatic void model_edge(input logic s, input logic r, input logic [3:0] a,
                                     input logic [7:0] d, input logic c);
    for (int k = 0; k < 2; k++) begin
      eo[k] = '0;
      ev[k] = 1'b0;
      if (left[k] > 0) begin
        left[k]--;
      end else if (c) begin
        left[k] = dep[k];
        for (int j = 0; j < 16; j++) m[k][j] = '0;
      end else if (s && r) begin
        if (int'(a) < dep[k]) m[k][a] = d;
      end else if (s && !r) begin
        ev[k] = 1'b1;
        eo[k] = (int'(a) < dep[k]) ? m[k][a] : 8'h00;
      end
    end
  endfunction

  // One clock: drive at the falling edge, update the model at the rising
  // edge, compare at the next falling edge.
  task automatic cycle(input string step, input logic s, input logic r,
                       input logic [3:0] a, input logic [7:0] d, input logic c);
    sel = s; rw = r; addr = a; din = d; clr = c;
    @(posedge clk);
    model_edge(s, r, a, d, c);
    @(negedge clk);
    check_all(step);
  endtask

  task automatic idle(input string step, input int n);
    for (int i = 0; i < n; i++) cycle(step, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
  endtask

  // Drop rst_n between edges and check the outputs react without a clock.
  task automatic async_reset(input string step);
    #2;
    rst_n = 1'b0;
    sel = 1'b0; clr = 1'b0;
    #1;
    model_reset();
    check_all(step);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    check_all("reset_hold");
    rst_n = 1'b1;

    idle("sweep_after_reset", 17);

    cycle("wr_a5", 1'b1, 1'b1, 4'd3, 8'hA5, 1'b0);
    cycle("rd_a5_issue", 1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
    idle("rd_a5", 2);

    for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 1'b1, 4'(i), 8'(i) ^ 8'h5A, 1'b0);
    for (int i = 0; i < 16; i++) cycle("b2b_read", 1'b1, 1'b0, 4'(i), 8'h00, 1'b0);
    idle("b2b_tail", 1);

    cycle("clr_vs_write", 1'b1, 1'b1, 4'd2, 8'hFF, 1'b1);
    for (int i = 0; i < 16; i++) cycle("busy_sel", 1'b1, 1'(i & 1), 4'(i), 8'hEE, 1'(i == 3));
    for (int i = 0; i < 16; i++) cycle("read_cleared", 1'b1, 1'b0, 4'(i), 8'h00, 1'b0);

    cycle("wr_9", 1'b1, 1'b1, 4'd9, 8'h33, 1'b0);
    cycle("wr_12", 1'b1, 1'b1, 4'd12, 8'h77, 1'b0);
    cycle("rd_12_issue", 1'b1, 1'b0, 4'd12, 8'h00, 1'b0);
    cycle("rd_9_issue", 1'b1, 1'b0, 4'd9, 8'h00, 1'b0);
    idle("oob_tail", 1);

    for (int i = 0; i < 400; i++) begin
      cycle("random", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 39) == 0));
    end
    idle("random_drain", 17);

    cycle("clr_pulse", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    idle("mid_sweep", 5);
    async_reset("rst_mid_sweep");
    for (int i = 0; i < 17; i++) cycle("resweep_sel", 1'b1, 1'b0, 4'(i % 16), 8'h00, 1'b0);

    cycle("wr_pend", 1'b1, 1'b1, 4'd5, 8'hC3, 1'b0);
    cycle("rd_pend", 1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
    async_reset("rst_pending_read");
    for (int i = 0; i < 17; i++) cycle("resweep2", 1'b1, 1'b0, 4'd5, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/memory_array.md
# memory_array

Parametrised word-addressed storage array, successor to the single-bit cell. Holds DEPTH words of WIDTH bits and keeps the cell's access convention: select plus a read/write mode bit, with rw=1 meaning write. Adds a registered one-cycle read path, out-of-range address handling, and a hardware clear sweep after reset or on request. Sits below the row/column decode level as the complete memory macro used by the top level.

## Interface
- WIDTH, 8, bits per word (>=1)
- DEPTH, 16, number of words (>=2; need not be a power of two)
- AW, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sel  in  1  access request for this cycle
- rw  in  1  mode: 1 = write, 0 = read
- addr  in  AW  word address
- in  in  WIDTH  write data
- clr  in  1  one-cycle pulse requesting a clear sweep of all words
- out  out  WIDTH  read data, valid only while out_valid=1, else 0
- out_valid  out  1  read data present this cycle
- busy  out  1  clear sweep in progress; requests are ignored

## Operation
- States: INIT (sweep), IDLE.
- Reset: state=INIT, sweep counter cnt=0, out=0, out_valid=0, busy=1. Storage words have no reset.
- INIT: each cycle write 0 to word cnt, then cnt+1. After word DEPTH-1 is written, go to IDLE and set cnt=0. busy=1 throughout INIT.
- IDLE with sel=1, rw=1: mem[addr] <= in at the edge.
- IDLE with sel=1, rw=0: next cycle out=mem[addr], out_valid=1.
- When no read was accepted in the previous cycle: out=0, out_valid=0. Output is gated to zero, matching the cell's behaviour.
- Out-of-range addr (addr>=DEPTH):
  - Write is dropped.
  - Read returns out=0 with out_valid=1.
- IDLE with clr=1: go to INIT with cnt=0. Any sel in that same cycle is dropped (clr wins).
- clr during INIT is ignored; the sweep is not restarted.
- Any sel while busy=1 has no effect and produces no out_valid.
- Async reset mid-sweep or mid-read:
  - Immediately forces the reset values above.
  - A pending out_valid is lost.
  - A sweep restarts from word 0 after rst_n rises.

## Timing
- Write latency: data is stored at the accepting edge and visible to a read accepted on the next cycle.
- Read latency: 1 cycle. A read accepted at edge N presents data in the cycle after edge N and clears after edge N+1 unless another read is accepted.
- Back-to-back reads give out_valid=1 on consecutive cycles.
- Write then read of the same address on consecutive cycles returns the new data.
- Sweep duration: exactly DEPTH cycles.
  - After reset: busy falls after the DEPTH-th rising edge following rst_n deassertion.
  - After clr: busy rises the cycle after clr is sampled and stays high DEPTH cycles.
- out_valid and busy are never both 1, except in the first sweep cycle, which completes a read accepted together with nothing else (impossible since clr wins). Net rule: out_valid=0 whenever busy=1.

## Structure
- Package memory_array_pkg contains:
  - state enum {INIT, IDLE}
  - constants RW_READ=1'b0, RW_WRITE=1'b1
- Sub-module memory_word: one WIDTH-bit register row with write enable and data input, no reset. It is instantiated DEPTH times by generate.
- The top level holds the FSM, sweep counter, address decode, read mux and output register.

## Test plan
- Reset, hold idle, DEPTH=16 -> busy=1 for 16 cycles then 0; out=0, out_valid=0 throughout.
- Write 0xA5 to addr 3, read addr 3 next cycle -> following cycle out=0xA5, out_valid=1; the cycle after that, out=0, out_valid=0.
- Write words 0..15 with addr^0x5A, then back-to-back reads of 0..15 -> 16 consecutive out_valid cycles with matching data.
- Fill array, pulse clr together with a write of 0xFF to addr 2 -> write dropped; busy 16 cycles; all reads return 0x00.
- DEPTH=10: write to addr 12, then read addr 12 -> out=0, out_valid=1; read addr 9 is unaffected by the write.
- Assert rst_n low mid-sweep and during a pending read -> out_valid drops immediately; full 16-cycle sweep restarts; sel while busy yields no out_valid.
